// File: rtl/priority_scan_encoder.sv
// Serialises a hit vector into the indices of its set bits, one per cycle, in priority order.
// Latency: first index valid the cycle after acceptance; stalls hold dout/dout_last; `PRIO_SCAN_B2B_EN` accepts the next vector on the last beat.
module priority_scan_encoder #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = $clog2(DIN_WIDTH),
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]           state;
  logic [DIN_WIDTH-1:0] pending;
  logic [DIN_WIDTH-1:0] cleared;
  logic [DIN_WIDTH-1:0] nxt;
  logic                 take_din;
  logic                 beat_done;

  function automatic logic [DOUT_WIDTH-1:0] prio_idx(input logic [DIN_WIDTH-1:0] v);
    prio_idx = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < DIN_WIDTH; i++)
        if (v[i]) prio_idx = DOUT_WIDTH'(i);
    end else begin
      for (int i = DIN_WIDTH - 1; i >= 0; i--)
        if (v[i]) prio_idx = DOUT_WIDTH'(i);
    end
  endfunction

  function automatic logic single_bit(input logic [DIN_WIDTH-1:0] v);
    single_bit = (v != '0) && ((v & (v - DIN_WIDTH'(1))) == '0);
  endfunction

`ifdef PRIO_SCAN_B2B_EN
  assign din_ready = rst_n & ((state == IDLE) | (dout_valid & dout_last & dout_ready));
`else
  assign din_ready = rst_n & (state == IDLE);
`endif

  // A vector taken on the final-beat handshake replaces the (then empty) remainder.
  always_comb begin
    take_din  = din_valid & din_ready;
    beat_done = dout_valid & dout_ready;
    cleared   = pending & ~(DIN_WIDTH'(1) << dout);
    nxt       = take_din ? din : cleared;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else if (take_din | beat_done) begin
      pending <= nxt;
      if (nxt != '0) begin
        state      <= SCAN;
        dout_valid <= 1'b1;
        dout       <= prio_idx(nxt);
        dout_last  <= single_bit(nxt);
      end else begin
        state      <= IDLE;
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Directed + randomized bench for priority_scan_encoder; LSB-first and MSB-first instances share stimulus.
module tb_priority_scan_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic        din_valid;
  logic        dout_ready;
  logic        din_ready_l, din_ready_m;
  logic [4:0]  dout_l, dout_m;
  logic        dout_valid_l, dout_valid_m;
  logic        dout_last_l, dout_last_m;

  int n_vec = 0;
  int n_err = 0;
  int ql[$];
  int qm[$];

  always #5 clk = ~clk;

  priority_scan_encoder #(.DIN_WIDTH(32), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready_l),
    .dout(dout_l), .dout_valid(dout_valid_l), .dout_ready(dout_ready), .dout_last(dout_last_l)
  );

  priority_scan_encoder #(.DIN_WIDTH(32), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready_m),
    .dout(dout_m), .dout_valid(dout_valid_m), .dout_ready(dout_ready), .dout_last(dout_last_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One output cycle: compare against the queue heads, then pop on handshake.
  task automatic step(input logic r);
    logic exp_rdy;
    dout_ready = r;
    #1;
`ifdef PRIO_SCAN_B2B_EN
    exp_rdy = (ql.size() == 1) && r;
`else
    exp_rdy = 1'b0;
`endif
    chk("vld_l", dout_valid_l, 1);
    chk("vld_m", dout_valid_m, 1);
    chk("rdy_scan", din_ready_l, exp_rdy);
    if (ql.size() != 0) begin
      chk("dout_l", dout_l, ql[0]);
      chk("last_l", dout_last_l, ql.size() == 1);
      chk("dout_m", dout_m, qm[0]);
      chk("last_m", dout_last_m, qm.size() == 1);
    end
    @(posedge clk);
    if (r && ql.size() != 0) begin
      void'(ql.pop_front());
      void'(qm.pop_front());
    end
  endtask

  task automatic load_model(input logic [31:0] v);
    ql.delete();
    qm.delete();
    for (int i = 0; i < 32; i++)
      if (v[i]) begin
        ql.push_back(i);
        qm.push_front(i);
      end
  endtask

  task automatic run_vec(input logic [31:0] v, input logic [31:0] mask);
    int t = 0;
    int c = 0;
    @(negedge clk); #1;
    while (!din_ready_l && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    chk("rdy_idle", din_ready_l, 1);
    din = v; din_valid = 1'b1; dout_ready = 1'b1;
    load_model(v);
    @(posedge clk); #1;
    din_valid = 1'b0; din = $urandom;
    while (ql.size() != 0 && c < 300) begin
      @(negedge clk);
      step(c < 32 ? mask[c] : 1'b1);
      c++;
    end
    @(negedge clk); #1;
    chk("idle_vld_l", dout_valid_l, 0);
    chk("idle_vld_m", dout_valid_m, 0);
    chk("idle_rdy", din_ready_l, 1);
    chk("idle_rdy_m", din_ready_m, 1);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] b2b_vld, b2b_dout, b2b_last;
    logic        acc;

    rst_n = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    #3;
    chk("rst_rdy", din_ready_l, 0);
    chk("rst_vld", dout_valid_l, 0);
    chk("rst_dout", dout_l, 0);
    chk("rst_last", dout_last_l, 0);
    @(negedge clk); rst_n = 1'b1;

    run_vec(32'h0000_0001, 32'hFFFF_FFFF);
    run_vec(32'h8000_0011, 32'hFFFF_FFFF);
    run_vec(32'h0000_00F0, 32'hFFFF_FFF9);
    run_vec(32'h0000_0000, 32'hFFFF_FFFF);
    run_vec(32'h0000_0100, 32'hFFFF_FFFF);
    run_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Reset in the middle of an all-ones scan.
    @(negedge clk); #1;
    din = 32'hFFFF_FFFF; din_valid = 1'b1; dout_ready = 1'b1;
    load_model(din);
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      step(1'b1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_vld_l", dout_valid_l, 0);
    chk("mrst_dout_l", dout_l, 0);
    chk("mrst_dout_m", dout_m, 0);
    chk("mrst_last", dout_last_l, 0);
    chk("mrst_rdy", din_ready_l, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("post_rst_vld", dout_valid_l, 0);
      chk("post_rst_rdy", din_ready_l, 1);
    end
    run_vec(32'h0000_0100, 32'hFFFF_FFFF);

    // Vectors 3 then 4 offered back to back with ready held high.
`ifdef PRIO_SCAN_B2B_EN
    b2b_vld = 32'h7; b2b_dout = {8'd0, 8'd2, 8'd1, 8'd0}; b2b_last = 32'h6;
`else
    b2b_vld = 32'hB; b2b_dout = {8'd2, 8'd0, 8'd1, 8'd0}; b2b_last = 32'hA;
`endif
    @(negedge clk); #1;
    din = 32'h3; din_valid = 1'b1; dout_ready = 1'b1;
    @(posedge clk); #1;
    din = 32'h4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("b2b_vld", dout_valid_l, b2b_vld[k]);
      if (b2b_vld[k]) begin
        chk("b2b_dout", dout_l, b2b_dout[8*k +: 8]);
        chk("b2b_last", dout_last_l, b2b_last[k]);
      end
      acc = din_ready_l;
      @(posedge clk); #1;
      if (acc) din_valid = 1'b0;
    end
    @(negedge clk); #1;
    chk("b2b_idle", dout_valid_l, 0);
    chk("b2b_idle_m", dout_valid_m, 0);

    for (int i = 0; i < 40; i++) begin
      v = $urandom & $urandom;
      if (i % 10 == 3) v = '0;
      if (i % 13 == 5) v = $urandom;
      run_vec(v, $urandom | $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/priority_scan_encoder.md
Name: priority_scan_encoder

Overview:
Sequential, parametrised successor to the combinational one-hot index encoder. Accepts a DIN_WIDTH-bit hit vector, such as per-channel threshold flags from the FRB detection chain. Emits the index of every set bit, one index per cycle, in priority order, under valid/ready flow control. Unlike a one-hot encoder, multi-hit vectors are fully resolved: no index is lost or OR-merged.

Parameters:
DIN_WIDTH, 32, width of input hit vector (>=2)
DOUT_WIDTH, $clog2(DIN_WIDTH), width of emitted index
MSB_FIRST, 0, 0 = lowest set bit emitted first; 1 = highest set bit first

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
din  in  DIN_WIDTH  hit vector
din_valid  in  1  din qualifier
din_ready  out  1  block can accept din
dout  out  DOUT_WIDTH  index of current set bit
dout_valid  out  1  dout qualifier
dout_ready  in  1  downstream accepts dout
dout_last  out  1  current index is the final set bit of the vector

Behaviour:
- One clock domain (clk). Asynchronous active-low reset rst_n.
- Reset (async assert, sync release):
  - state = IDLE, pending = 0.
  - dout = 0, dout_valid = 0, dout_last = 0.
  - din_ready = 0 while rst_n is low.
- States: IDLE, SCAN.
- IDLE:
  - din_ready = 1.
  - On din_valid & din_ready with din != 0: pending <= din, go to SCAN.
  - dout/dout_valid/dout_last are registered and valid the next cycle: accept at edge k, dout_valid = 1 after edge k.
  - din == 0 is accepted and discarded. No output beat; stay in IDLE.
- SCAN:
  - din_ready = 0.
  - dout = priority index of pending (lowest set bit if MSB_FIRST=0, highest if 1).
  - dout_last = 1 iff pending has exactly one bit set.
  - On dout_valid & dout_ready: clear that bit in pending. The next beat is registered on the same edge, so there are no bubbles: N set bits produce N consecutive beats under continuous ready.
  - After the handshake with dout_last = 1: go to IDLE; dout_valid = 0 next cycle.
- Stall: while dout_valid & !dout_ready, dout and dout_last hold stable and pending is unchanged.
- din is ignored whenever din_ready = 0. There is no internal buffering beyond pending.
- Throughput without the optional feature: a vector with N hits occupies N+1 cycles (N beats plus one IDLE accept cycle).
- Index arithmetic: dout is an unsigned bit position, 0..DIN_WIDTH-1, zero-extended to DOUT_WIDTH.
- Full vector (all ones): DIN_WIDTH beats, in order 0..DIN_WIDTH-1 (or reversed if MSB_FIRST=1), last beat flagged.
- Reset mid-SCAN: remaining indices are dropped; outputs return to reset values immediately.

Optional Feature:
PRIO_SCAN_B2B_EN
- Defined: din_ready = IDLE | (dout_valid & dout_last & dout_ready).
  - A new nonzero vector accepted on the final-beat handshake loads pending and presents its first index the next cycle, with no IDLE gap (N cycles per vector).
  - A zero vector accepted there behaves as in IDLE: the block returns to IDLE with no output.
- Undefined: din_ready is high in IDLE only, as described in Behaviour.

Test Plan:
- Reset then din=32'h0000_0001 valid one cycle, dout_ready=1 -> one beat dout=0, dout_last=1; din_ready back to 1 the following cycle.
- din=32'h8000_0011, MSB_FIRST=0, dout_ready=1 -> beats 0, 4, 31 on consecutive cycles; dout_last only on 31. With MSB_FIRST=1 -> 31, 4, 0.
- din=32'h0000_00F0, dout_ready toggling 1,0,0,1,1,1 -> indices 4,5,6,7, each held stable during the low-ready cycles; no index duplicated or skipped.
- din=0 valid -> accepted (din_ready=1), dout_valid stays 0; a following din=32'h0000_0100 -> single beat dout=8, last=1.
- din=32'hFFFF_FFFF, assert rst_n=0 after 5 beats -> dout_valid=0 and dout=0 asynchronously; after release, din_ready=1 and no stale beats appear.
- PRIO_SCAN_B2B_EN: vectors 32'h3 then 32'h4 back-to-back, ready=1 -> beats 0, 1(last), 2(last) on three consecutive cycles; without the macro, a one-cycle gap appears before index 2.
